// File: rtl/bufer_mem_wb_param.sv
// MEM/WB pipeline register with DEPTH stages, stall/flush control, register-0
// write suppression, a two-port forwarding lookup and a retired-instruction counter.
module bufer_mem_wb_param #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned ZERO_GUARD = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] EnRD,
  input  logic [DATA_W-1:0] EnALU,
  input  logic [REG_W-1:0]  EnWR,
  input  logic [1:0]        EnWB,
  input  logic              EnValid,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] SalRD,
  output logic [DATA_W-1:0] SalALU,
  output logic [REG_W-1:0]  SalWR,
  output logic [1:0]        SalWB,
  output logic              SalValid,
  input  logic [REG_W-1:0]  qA,
  input  logic [REG_W-1:0]  qB,
  output logic              hitA,
  output logic              hitB,
  output logic [DATA_W-1:0] fwdA,
  output logic [DATA_W-1:0] fwdB,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned LAST = DEPTH - 1;

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("bufer_mem_wb_param: DEPTH must be in 1..4");
  end

  logic [DATA_W-1:0] r_rd    [DEPTH];
  logic [DATA_W-1:0] r_alu   [DEPTH];
  logic [REG_W-1:0]  r_wr    [DEPTH];
  logic [1:0]        r_wb    [DEPTH];
  logic              r_valid [DEPTH];
  logic [CNT_W-1:0]  r_retired;
  logic [1:0]        w_wb_in;

  // Entry WB: bubbles carry no control, writes to register 0 are dropped
  always_comb begin
    w_wb_in = EnWB & {2{EnValid}};
    if ((ZERO_GUARD != 0) && (EnWR == '0)) begin
      w_wb_in[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_rd[k]    <= '0;
        r_alu[k]   <= '0;
        r_wr[k]    <= '0;
        r_wb[k]    <= '0;
        r_valid[k] <= 1'b0;
      end
      r_retired <= '0;
    end else if (flush) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_wb[k]    <= '0;
        r_valid[k] <= 1'b0;
      end
    end else if (!stall) begin
      r_rd[0]    <= EnRD;
      r_alu[0]   <= EnALU;
      r_wr[0]    <= EnWR;
      r_wb[0]    <= w_wb_in;
      r_valid[0] <= EnValid;
      for (int k = 1; k < int'(DEPTH); k++) begin
        r_rd[k]    <= r_rd[k-1];
        r_alu[k]   <= r_alu[k-1];
        r_wr[k]    <= r_wr[k-1];
        r_wb[k]    <= r_wb[k-1];
        r_valid[k] <= r_valid[k-1];
      end
      if (r_valid[LAST]) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign SalRD    = r_rd[LAST];
  assign SalALU   = r_alu[LAST];
  assign SalWR    = r_wr[LAST];
  assign SalWB    = r_wb[LAST] & {2{r_valid[LAST]}};
  assign SalValid = r_valid[LAST];
  assign retired  = r_retired;

  // Scan oldest to youngest so the youngest matching stage wins
  always_comb begin
    hitA = 1'b0;
    hitB = 1'b0;
    fwdA = '0;
    fwdB = '0;
    for (int k = int'(LAST); k >= 0; k--) begin
      if (r_valid[k] && r_wb[k][0] && (r_wr[k] == qA) && (qA != '0)) begin
        hitA = 1'b1;
        fwdA = r_wb[k][1] ? r_rd[k] : r_alu[k];
      end
      if (r_valid[k] && r_wb[k][0] && (r_wr[k] == qB) && (qB != '0)) begin
        hitB = 1'b1;
        fwdB = r_wb[k][1] ? r_rd[k] : r_alu[k];
      end
    end
  end

endmodule

// File: tb/tb_bufer_mem_wb_param.sv
// Scoreboard bench: two configurations (DEPTH=3/guard on/16-bit counter and
// DEPTH=2/guard off/4-bit counter) share one stimulus stream.
module tb_bufer_mem_wb_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] en_rd, en_alu;
  logic [4:0]  en_wr, q_a, q_b;
  logic [1:0]  en_wb;
  logic        en_valid, stall, flush;

  logic [31:0] sal_rd [2];
  logic [31:0] sal_alu[2];
  logic [31:0] fwd_a  [2];
  logic [31:0] fwd_b  [2];
  logic [4:0]  sal_wr [2];
  logic [1:0]  sal_wb [2];
  logic        sal_valid[2];
  logic        hit_a  [2];
  logic        hit_b  [2];
  logic [15:0] ret_a;
  logic [3:0]  ret_b;
  logic [15:0] ret_o  [2];

  int n_checks = 0;
  int n_fail   = 0;

  assign ret_o[0] = ret_a;
  assign ret_o[1] = {12'b0, ret_b};

  always #5 clk = ~clk;

  bufer_mem_wb_param #(.DATA_W(32), .REG_W(5), .DEPTH(3), .ZERO_GUARD(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .EnRD(en_rd), .EnALU(en_alu), .EnWR(en_wr), .EnWB(en_wb),
    .EnValid(en_valid), .stall(stall), .flush(flush),
    .SalRD(sal_rd[0]), .SalALU(sal_alu[0]), .SalWR(sal_wr[0]), .SalWB(sal_wb[0]),
    .SalValid(sal_valid[0]), .qA(q_a), .qB(q_b), .hitA(hit_a[0]), .hitB(hit_b[0]),
    .fwdA(fwd_a[0]), .fwdB(fwd_b[0]), .retired(ret_a));

  bufer_mem_wb_param #(.DATA_W(32), .REG_W(5), .DEPTH(2), .ZERO_GUARD(0), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .EnRD(en_rd), .EnALU(en_alu), .EnWR(en_wr), .EnWB(en_wb),
    .EnValid(en_valid), .stall(stall), .flush(flush),
    .SalRD(sal_rd[1]), .SalALU(sal_alu[1]), .SalWR(sal_wr[1]), .SalWB(sal_wb[1]),
    .SalValid(sal_valid[1]), .qA(q_a), .qB(q_b), .hitA(hit_a[1]), .hitB(hit_b[1]),
    .fwdA(fwd_a[1]), .fwdB(fwd_b[1]), .retired(ret_b));

  function automatic int depth_of(int m);
    return (m == 0) ? 3 : 2;
  endfunction

  function automatic bit guard_of(int m);
    return (m == 0);
  endfunction

  function automatic int unsigned cmask_of(int m);
    return (m == 0) ? 32'hFFFF : 32'h000F;
  endfunction

  // In-flight instructions, oldest first; stage = adv - stamp
  typedef struct {
    int          m;
    int unsigned stamp;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [1:0]  wb;
  } txn_t;

  txn_t        sb[$];
  int unsigned adv;
  int unsigned ret_m[2];

  function automatic int first_idx(int m);
    for (int i = 0; i < sb.size(); i++) if (sb[i].m == m) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", nm, m, $time, act, exp);
    end
  endtask

  // Reference model: advance/stall/flush on the instruction list
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      adv = 0;
      ret_m[0] = 0;
      ret_m[1] = 0;
    end else if (flush) begin
      sb.delete();
    end else if (!stall) begin
      for (int m = 0; m < 2; m++) begin
        int idx;
        idx = first_idx(m);
        if (idx >= 0 && (adv - sb[idx].stamp) == 32'(depth_of(m) - 1)) begin
          sb.delete(idx);
          ret_m[m] = (ret_m[m] + 1) & cmask_of(m);
        end
      end
      adv++;
      if (en_valid) begin
        for (int m = 0; m < 2; m++) begin
          txn_t t;
          t.m = m; t.stamp = adv; t.rd = en_rd; t.alu = en_alu; t.wr = en_wr; t.wb = en_wb;
          if (guard_of(m) && en_wr == 5'd0) t.wb[0] = 1'b0;
          sb.push_back(t);
        end
      end
    end
  end

  task automatic check_fwd(input int m, input string nm, input logic [4:0] q,
                           input logic hit, input logic [31:0] fwd);
    logic        eh;
    logic [31:0] ef;
    eh = 1'b0;
    ef = 32'h0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].m == m && sb[i].wb[0] && sb[i].wr == q && q != 5'd0) begin
        eh = 1'b1;
        ef = sb[i].wb[1] ? sb[i].rd : sb[i].alu;
        break;
      end
    end
    chk({"hit", nm}, m, 32'(hit), 32'(eh));
    chk({"fwd", nm}, m, fwd, ef);
  endtask

  // Monitor: compare the presented outputs with the model front entry
  always @(negedge clk) begin
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        int idx;
        bit ev;
        idx = first_idx(m);
        ev  = (idx >= 0) && ((adv - sb[idx].stamp) == 32'(depth_of(m) - 1));
        chk("SalValid", m, 32'(sal_valid[m]), 32'(ev));
        if (ev) begin
          chk("SalRD",  m, sal_rd[m],  sb[idx].rd);
          chk("SalALU", m, sal_alu[m], sb[idx].alu);
          chk("SalWR",  m, 32'(sal_wr[m]), 32'(sb[idx].wr));
          chk("SalWB",  m, 32'(sal_wb[m]), 32'(sb[idx].wb));
        end else begin
          chk("SalWB_idle", m, 32'(sal_wb[m]), 32'h0);
        end
        chk("retired", m, 32'(ret_o[m]), ret_m[m]);
        check_fwd(m, "A", q_a, hit_a[m], fwd_a[m]);
        check_fwd(m, "B", q_b, hit_b[m], fwd_b[m]);
      end
    end
  end

  task automatic check_zero(input string nm);
    for (int m = 0; m < 2; m++) begin
      chk({nm, "_valid"}, m, 32'(sal_valid[m]), 32'h0);
      chk({nm, "_rd"},    m, sal_rd[m], 32'h0);
      chk({nm, "_alu"},   m, sal_alu[m], 32'h0);
      chk({nm, "_wr"},    m, 32'(sal_wr[m]), 32'h0);
      chk({nm, "_wb"},    m, 32'(sal_wb[m]), 32'h0);
      chk({nm, "_hit"},   m, 32'({hit_a[m], hit_b[m]}), 32'h0);
      chk({nm, "_fwdA"},  m, fwd_a[m], 32'h0);
      chk({nm, "_fwdB"},  m, fwd_b[m], 32'h0);
      chk({nm, "_ret"},   m, 32'(ret_o[m]), 32'h0);
    end
  endtask

  task automatic drive(input logic [31:0] rd, input logic [31:0] alu, input logic [4:0] wr,
                       input logic [1:0] wb, input logic v, input logic st, input logic fl,
                       input logic [4:0] qa, input logic [4:0] qb);
    @(posedge clk);
    #1;
    en_rd = rd; en_alu = alu; en_wr = wr; en_wb = wb; en_valid = v;
    stall = st; flush = fl; q_a = qa; q_b = qb;
  endtask

  task automatic drive_rand();
    drive($urandom, $urandom, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 19) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
  endtask

  initial begin
    en_rd = '0; en_alu = '0; en_wr = '0; en_wb = '0; en_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; q_a = '0; q_b = '0;

    // Reset held with random inputs
    repeat (3) drive_rand();
    @(negedge clk);
    check_zero("rst_hold");
    drive(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    rst = 1'b0;

    // Pass-through
    drive(32'hDEADBEEF, 32'h10, 5'd7, 2'b11, 1'b1, 1'b0, 1'b0, 5'd7, 5'd0);
    repeat (4) drive(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd7, 5'd0);

    // Fill, stall, then flush during stall
    for (int i = 1; i <= 3; i++)
      drive(32'(i * 16), 32'(i), 5'(i), 2'b01, 1'b1, 1'b0, 1'b0, 5'd2, 5'd3);
    repeat (4) drive(32'h1234, 32'h5678, 5'd4, 2'b01, 1'b1, 1'b1, 1'b0, 5'd2, 5'd3);
    drive(32'h0, 32'h0, 5'd0, 2'b01, 1'b1, 1'b1, 1'b1, 5'd2, 5'd3);
    repeat (2) drive(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd2, 5'd3);

    // Register-0 guard
    drive(32'h77, 32'h88, 5'd0, 2'b01, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
    repeat (3) drive(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);

    // Forwarding priority: older RD entry vs younger ALU entry on the same register
    drive(32'hBB, 32'h11, 5'd5, 2'b11, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5);
    drive(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5);
    drive(32'h22, 32'hAA, 5'd5, 2'b01, 1'b1, 1'b0, 1'b0, 5'd5, 5'd5);
    drive(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd5, 5'd0);
    drive(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd5);
    repeat (4) drive(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5);

    // Randomized traffic (also wraps the 4-bit counter many times)
    repeat (3000) drive_rand();

    // Asynchronous reset mid-cycle with a full pipeline
    repeat (3) drive($urandom, $urandom, 5'($urandom_range(1, 7)), 2'b11, 1'b1, 1'b0, 1'b0,
                     5'($urandom_range(1, 7)), 5'($urandom_range(1, 7)));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    drive(32'h0, 32'h0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    rst = 1'b0;

    repeat (50) drive_rand();
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bufer_mem_wb_param.md
Name: bufer_mem_wb_param

Overview:
Parametrised MEM/WB pipeline register, the successor to the fixed 32-bit single-stage buffer. It carries memory read data, the ALU result, the destination register and the WB control bits from MEM to writeback through DEPTH register stages. Each stage adds a valid bit, stall/flush control and register-0 write suppression. The block also exposes a two-port forwarding lookup for the hazard unit and a retired-instruction counter.

Parameters:
DATA_W, 32, width of read-data and ALU-result paths
REG_W, 5, width of destination register address
DEPTH, 1, number of pipeline stages (legal 1..4)
ZERO_GUARD, 1, when 1 a RegWrite to register 0 is suppressed
CNT_W, 16, width of retired counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
EnRD  in  DATA_W  memory read data
EnALU  in  DATA_W  ALU result
EnWR  in  REG_W  destination register
EnWB  in  2  WB control: [0]=RegWrite, [1]=MemToReg
EnValid  in  1  input slot holds a real instruction
stall  in  1  hold all stages
flush  in  1  invalidate all stages
SalRD  out  DATA_W  read data, last stage
SalALU  out  DATA_W  ALU result, last stage
SalWR  out  REG_W  destination register, last stage
SalWB  out  2  WB control, last stage (gated by valid)
SalValid  out  1  last stage valid
qA, qB  in  REG_W each  forwarding lookup addresses
hitA, hitB  out  1 each  lookup match
fwdA, fwdB  out  DATA_W each  forwarded value
retired  out  CNT_W  count of instructions leaving last stage

Behaviour:
- Reset (async, any time, including mid-stall or mid-flush): every stage's data, WR, WB and valid clear to 0. All outputs read 0, retired=0, hit=0, fwd=0.
- Latency: an input captured at edge N appears on the Sal* outputs after edge N+DEPTH-1, i.e. DEPTH cycles of latency with no stall.
- Per edge, priority flush > stall > advance:
  - flush=1: all valid bits and all stored WB bits clear to 0. Data and WR are don't-care and are held. Flush takes effect even when stall=1.
  - stall=1, flush=0: all stages hold, and the retired counter holds.
  - Otherwise: stage0 loads the inputs, and stage k loads stage k-1.
- Valid gating: a stage loads WB as EnWB & {2{EnValid}}. SalWB is the stored WB & {2{SalValid}}, so an invalid stage never asserts RegWrite.
- ZERO_GUARD=1: RegWrite is cleared on entry when EnWR==0. MemToReg passes through unchanged.
- Mux semantics for forwarding: a stage's value is its RD when WB[1]=1, else its ALU result.
- Forwarding lookup (combinational from stage registers):
  - hitA=1 when some stage has valid=1, RegWrite=1, WR==qA and qA!=0. fwdA is that stage's value.
  - When several stages match, the youngest (lowest index) wins.
  - When there is no hit, fwdA=0. Port B is identical using qB.
- Retired counter: increments on any edge where SalValid=1, stall=0 and flush=0. It wraps modulo 2^CNT_W with no saturation.
- A flush on the same edge as a retiring instruction does not count it.
- DEPTH outside 1..4 is a configuration error; the implementation checks it at elaboration.

Test Plan:
- Reset: hold rst=1 with random inputs -> all outputs 0. Assert rst asynchronously mid-cycle with 3 valid entries (DEPTH=3) -> outputs 0 immediately with no clock edge, retired=0.
- Pass-through: DEPTH=2 with EnRD=0xDEADBEEF, EnALU=0x10, EnWR=7, EnWB=2'b11, EnValid=1 at edge 0 -> at edge 1 SalRD=0xDEADBEEF, SalWR=7, SalWB=2'b11, SalValid=1; retired=1 after edge 2.
- Stall/flush: fill DEPTH=3 with WR=1,2,3, stall 4 cycles -> outputs frozen, retired unchanged. Then flush=1 together with stall=1 -> SalValid=0, SalWB=0, hit=0 next cycle.
- Zero guard: EnWR=0, EnWB=2'b01, EnValid=1 -> SalWB=2'b00. With ZERO_GUARD=0 -> SalWB=2'b01.
- Forwarding priority: DEPTH=3 with stage0 WR=5, ALU=0xAA, MemToReg=0 and stage2 WR=5, RD=0xBB, MemToReg=1, qA=5 -> hitA=1, fwdA=0xAA. Invalidate stage0 -> fwdA=0xBB. Set qA=0 -> hitA=0.
- Wrap: CNT_W=4 with 17 valid retirements -> retired=1.
